dice_roll_engine: RTL and testbench

//  Parametrised successor to the die post-processor. Sits between the TRNG (stop/valid sampling

---
 rtl/dice_roll_engine.sv | 175 +++++++++++++++++
 tb/tb_dice_roll_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_engine.sv
// dice_roll_engine: gates a TRNG, rejection-samples one sample per request and
// returns roll = sample % faces(die) over a valid/ready handshake.
// Latency: i_req -> o_stop low 2 cycles later; accepted i_valid -> o_roll_valid 2 cycles later.
// Backpressure: result held in S_HOLD until i_roll_ready; requests ignored while busy.
//
// Ports: i_clk, i_reset_n (synchronous, active-low), i_req/i_dieSelect (request),
//        i_randomData/i_valid/o_stop (TRNG sampling interface), o_busy,
//        o_dieRoll/o_roll_valid/i_roll_ready (result handshake), o_sel_err, o_rej_cnt.
// Build option: define DICE_ONE_BASED_EN for rolls in 1..N instead of 0..N-1.
module dice_roll_engine #(
  parameter int RND_W       = 7,
  parameter int ROLL_W      = 5,
  parameter int TIMEOUT_CYC = 255,
  parameter int REJ_CNT_W   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_req,
  input  logic [3:0]           i_dieSelect,
  input  logic [RND_W-1:0]     i_randomData,
  input  logic                 i_valid,
  output logic                 o_stop,
  output logic                 o_busy,
  output logic [ROLL_W-1:0]    o_dieRoll,
  output logic                 o_roll_valid,
  input  logic                 i_roll_ready,
  output logic                 o_sel_err,
  output logic [REJ_CNT_W-1:0] o_rej_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam int LW   = RND_W + 1;
  localparam int SPAN = 2 ** RND_W;

`ifdef DICE_ONE_BASED_EN
  localparam logic [ROLL_W-1:0] ROLL_OFS = ROLL_W'(1);
`else
  localparam logic [ROLL_W-1:0] ROLL_OFS = ROLL_W'(0);
`endif

  // Largest multiple of the face count that fits in the sample range; samples at
  // or above it are discarded so every face is equally likely.
  function automatic logic [LW-1:0] limit_f(input logic [2:0] s);
    case (s)
      3'd0:    return LW'((SPAN / 4) * 4);
      3'd1:    return LW'((SPAN / 6) * 6);
      3'd2:    return LW'((SPAN / 8) * 8);
      3'd3:    return LW'((SPAN / 10) * 10);
      3'd4:    return LW'((SPAN / 12) * 12);
      default: return LW'((SPAN / 20) * 20);
    endcase
  endfunction

  // Constant divisors per branch keep each modulo a fixed-function block.
  function automatic logic [RND_W-1:0] mod_f(input logic [RND_W-1:0] r, input logic [2:0] s);
    case (s)
      3'd0:    return r % RND_W'(4);
      3'd1:    return r % RND_W'(6);
      3'd2:    return r % RND_W'(8);
      3'd3:    return r % RND_W'(10);
      3'd4:    return r % RND_W'(12);
      default: return r % RND_W'(20);
    endcase
  endfunction

  logic [2:0]           state_q, state_d;
  logic [2:0]           sel_q, sel_d;
  logic [RND_W-1:0]     r_q, r_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic                 stop_q, stop_d;
  logic [ROLL_W-1:0]    roll_q, roll_d;
  logic                 roll_vld_q, roll_vld_d;
  logic                 sel_err_q, sel_err_d;
  logic [REJ_CNT_W-1:0] rej_q, rej_d;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    r_d        = r_q;
    to_cnt_d   = to_cnt_q;
    stop_d     = 1'b1;
    roll_d     = roll_q;
    roll_vld_d = roll_vld_q;
    sel_err_d  = 1'b0;
    rej_d      = rej_q;
    case (state_q)
      S_IDLE: begin
        if (i_req) begin
          if (i_dieSelect <= 4'd5) begin
            sel_d   = i_dieSelect[2:0];
            state_d = S_ARM;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      S_ARM: begin
        stop_d   = 1'b0;
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        // A sample arriving on the expiry cycle is still used.
        if (i_valid) begin
          r_d = i_randomData;
          if ({1'b0, i_randomData} < limit_f(sel_q)) begin
            state_d = S_CALC;
          end else begin
            if (rej_q != '1) rej_d = rej_q + REJ_CNT_W'(1);
            state_d = S_ARM;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_ARM;
        end else begin
          stop_d   = 1'b0;
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_CALC: begin
        roll_d     = ROLL_W'(mod_f(r_q, sel_q)) + ROLL_OFS;
        roll_vld_d = 1'b1;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (i_roll_ready) begin
          roll_vld_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: begin
        roll_vld_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      r_q        <= '0;
      to_cnt_q   <= '0;
      stop_q     <= 1'b1;
      roll_q     <= '0;
      roll_vld_q <= 1'b0;
      sel_err_q  <= 1'b0;
      rej_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      r_q        <= r_d;
      to_cnt_q   <= to_cnt_d;
      stop_q     <= stop_d;
      roll_q     <= roll_d;
      roll_vld_q <= roll_vld_d;
      sel_err_q  <= sel_err_d;
      rej_q      <= rej_d;
    end
  end

  assign o_stop       = stop_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_dieRoll    = roll_q;
  assign o_roll_valid = roll_vld_q;
  assign o_sel_err    = sel_err_q;
  assign o_rej_cnt    = rej_q;

endmodule

// File: tb/tb_dice_roll_engine.sv
module tb_dice_roll_engine;
  localparam int RND_W       = 7;
  localparam int ROLL_W      = 5;
  localparam int TIMEOUT_CYC = 255;
  localparam int REJ_CNT_W   = 8;
  localparam int REJ_MAX     = (1 << REJ_CNT_W) - 1;
`ifdef DICE_ONE_BASED_EN
  localparam int ONE = 1;
`else
  localparam int ONE = 0;
`endif

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic                 i_reset_n, i_req, i_valid, i_roll_ready;
  logic [3:0]           i_dieSelect;
  logic [RND_W-1:0]     i_randomData;
  logic                 o_stop, o_busy, o_roll_valid, o_sel_err;
  logic [ROLL_W-1:0]    o_dieRoll;
  logic [REJ_CNT_W-1:0] o_rej_cnt;

  dice_roll_engine #(.RND_W(RND_W), .ROLL_W(ROLL_W), .TIMEOUT_CYC(TIMEOUT_CYC),
                     .REJ_CNT_W(REJ_CNT_W)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req(i_req), .i_dieSelect(i_dieSelect),
    .i_randomData(i_randomData), .i_valid(i_valid), .o_stop(o_stop), .o_busy(o_busy),
    .o_dieRoll(o_dieRoll), .o_roll_valid(o_roll_valid), .i_roll_ready(i_roll_ready),
    .o_sel_err(o_sel_err), .o_rej_cnt(o_rej_cnt)
  );

  int checks = 0;
  int errors = 0;
  int exp_rej = 0;
  logic [RND_W-1:0] samp[$];

  // Reference: die faces and the unbiased acceptance bound.
  function automatic int faces(input int sel);
    case (sel)
      0: return 4;
      1: return 6;
      2: return 8;
      3: return 10;
      4: return 12;
      default: return 20;
    endcase
  endfunction

  function automatic int lim(input int sel);
    return ((2 ** RND_W) / faces(sel)) * faces(sel);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Called in the first cycle o_roll_valid should be high.
  task automatic finish_hold(input int exp_roll, input int hold);
    chk("valid_rise", o_roll_valid, 1);
    chk("roll_value", o_dieRoll, exp_roll);
    chk("hold_stop", o_stop, 1);
    for (int i = 0; i < hold; i++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_randomData = RND_W'($urandom);
      tick();
      chk("hold_valid", o_roll_valid, 1);
      chk("hold_roll_stable", o_dieRoll, exp_roll);
    end
    i_valid = 1'b0;
    i_roll_ready = 1'b1;
    tick();
    i_roll_ready = 1'b0;
    chk("accept_valid_low", o_roll_valid, 0);
    chk("accept_busy_low", o_busy, 0);
    chk("accept_stop_high", o_stop, 1);
  endtask

  // Runs one request using the samples queued in samp; the list ends with an accepted sample.
  task automatic do_roll(input int sel, input int hold);
    chk("idle_busy", o_busy, 0);
    chk("idle_stop", o_stop, 1);
    i_req = 1'b1;
    i_dieSelect = 4'(sel);
    tick();
    i_req = 1'b0;
    i_dieSelect = 4'($urandom);
    i_valid = 1'b1;                    // ignored while arming
    i_randomData = RND_W'($urandom);
    chk("arm_busy", o_busy, 1);
    chk("arm_stop", o_stop, 1);
    for (int k = 0; k < samp.size(); k++) begin
      tick();
      i_valid = 1'b0;
      chk("wait_stop_low", o_stop, 0);
      repeat ($urandom_range(0, 3)) tick();
      i_randomData = samp[k];
      i_valid = 1'b1;
      tick();
      i_valid = 1'b0;
      chk("capture_stop_high", o_stop, 1);
      if (int'(samp[k]) >= lim(sel)) begin
        if (exp_rej < REJ_MAX) exp_rej++;
        chk("rej_cnt", o_rej_cnt, exp_rej);
      end else begin
        chk("calc_not_valid", o_roll_valid, 0);
        tick();
        finish_hold((int'(samp[k]) % faces(sel)) + ONE, hold);
        break;
      end
    end
  endtask

  initial begin
    int zeros;
    int sel;
    int r;
    i_reset_n = 1'b0; i_req = 1'b0; i_dieSelect = '0; i_randomData = '0;
    i_valid = 1'b0; i_roll_ready = 1'b0;
    repeat (3) tick();
    chk("rst_stop", o_stop, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_roll", o_dieRoll, 0);
    chk("rst_valid", o_roll_valid, 0);
    chk("rst_sel_err", o_sel_err, 0);
    chk("rst_rej", o_rej_cnt, 0);
    i_reset_n = 1'b1;
    tick();

    // Invalid die selects are dropped with a single-cycle error pulse.
    foreach (samp[i]) samp.delete();
    for (int s = 15; s >= 6; s -= 9) begin
      i_req = 1'b1;
      i_dieSelect = 4'(s);
      tick();
      i_req = 1'b0;
      chk("sel_err_pulse", o_sel_err, 1);
      chk("sel_err_stop", o_stop, 1);
      chk("sel_err_busy", o_busy, 0);
      tick();
      chk("sel_err_clear", o_sel_err, 0);
      chk("sel_err_idle", o_busy, 0);
    end

    samp = '{7'd119};          do_roll(5, 0);
    samp = '{7'd125, 7'd37};   do_roll(3, 2);
    samp = '{7'd126, 7'd0};    do_roll(1, 1);
    samp = '{7'd127};          do_roll(2, 0);

    // Reset while the oscillator is running.
    i_req = 1'b1; i_dieSelect = 4'd5;
    tick();
    i_req = 1'b0;
    tick();
    chk("pre_rst_stop", o_stop, 0);
    chk("pre_rst_rej", o_rej_cnt, exp_rej);
    i_reset_n = 1'b0;
    tick();
    exp_rej = 0;
    chk("midrst_stop", o_stop, 1);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_valid", o_roll_valid, 0);
    chk("midrst_rej", o_rej_cnt, 0);
    i_reset_n = 1'b1;
    tick();

    // Timeout re-arm, then a sample on the expiry cycle wins.
    i_req = 1'b1; i_dieSelect = 4'd0;
    tick();
    i_req = 1'b0;
    tick();
    zeros = 0;
    for (int i = 0; i < TIMEOUT_CYC; i++) begin
      if (o_stop == 1'b0) zeros++;
      tick();
    end
    chk("timeout_low_len", zeros, TIMEOUT_CYC);
    chk("timeout_pulse", o_stop, 1);
    chk("timeout_busy", o_busy, 1);
    tick();
    chk("timeout_rearm", o_stop, 0);
    repeat (TIMEOUT_CYC - 1) tick();
    chk("timeout_last_wait", o_stop, 0);
    i_valid = 1'b1; i_randomData = 7'd35;
    tick();
    i_valid = 1'b0;
    chk("valid_vs_timeout_stop", o_stop, 1);
    tick();
    finish_hold((35 % 4) + ONE, 10);

    // Random back-to-back rolls.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 5);
      samp.delete();
      do begin
        r = $urandom_range(0, (2 ** RND_W) - 1);
        if (samp.size() >= 4 && r >= lim(sel)) r = $urandom_range(0, lim(sel) - 1);
        samp.push_back(RND_W'(r));
      end while (r >= lim(sel));
      do_roll(sel, $urandom_range(0, 3));
    end

    // Rejection counter saturates.
    samp.delete();
    repeat (REJ_MAX + 5) samp.push_back(7'd125);
    samp.push_back(7'd37);
    do_roll(3, 0);
    chk("rej_saturated", o_rej_cnt, REJ_MAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
